// File: rtl/io_timer.sv
// io_timer -- memory-mapped 16-bit down-counting timer and interrupt source.
//
// Sits on the even/odd split I/O bus inside iosystem. An 8-byte register
// window at BASEADDR holds:
//   +0 CTRL      b0 EN, b1 PERIODIC, b2 IE, b3 LOAD (write-1 strobe, reads 0)
//   +1 STATUS    b0 EXP, write 1 to clear
//   +2 RELOAD_LO +3 RELOAD_HI
//   +4 COUNT_LO  +5 COUNT_HI (read-only, LO read latches HI)
//   +6 PRESCALE
//   +7 COMPARE   (only with IO_TIMER_PWM_EN defined, otherwise reads 0)
//
// Optional feature macro: IO_TIMER_PWM_EN (adds COMPARE and a PWM output).
//
// Ports:
//   clk                    system clock, all state on posedge
//   reset                  asynchronous, active-low
//   read_addr_even/odd     word addresses of the read lanes
//   read_data_even/odd     registered read data (latency 1)
//   write_addr_even/odd    word addresses of the write lanes
//   write_data_even/odd    write data
//   write_en_even/odd      write strobes
//   interrupt              level interrupt, EXP & IE, from a flop
//   pwm_out                PWM output (tied 0 without IO_TIMER_PWM_EN)
module io_timer #(
  parameter logic [15:0] BASEADDR       = 16'h0010,
  parameter logic [7:0]  PRESCALE_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] read_addr_even,
  input  logic [14:0] read_addr_odd,
  output logic [7:0]  read_data_even,
  output logic [7:0]  read_data_odd,
  input  logic [14:0] write_addr_even,
  input  logic [14:0] write_addr_odd,
  input  logic [7:0]  write_data_even,
  input  logic [7:0]  write_data_odd,
  input  logic        write_en_even,
  input  logic        write_en_odd,
  output logic        interrupt,
  output logic        pwm_out
);

  localparam int DATA_W = 8;

  // Architectural state
  logic              en;
  logic              periodic;
  logic              ie;
  logic              exp_flag;
  logic [15:0]       reload;
  logic [15:0]       count;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] presc_cnt;
  logic [DATA_W-1:0] hi_latch;
`ifdef IO_TIMER_PWM_EN
  logic [DATA_W-1:0] compare;
`endif

  function automatic logic in_window(input logic [15:0] ba);
    return ba[15:3] == BASEADDR[15:3];
  endfunction

  // Read multiplexer over the pre-edge register state. live_hi selects the
  // live count high byte when the other lane reads COUNT_LO this cycle.
  function automatic logic [DATA_W-1:0] reg_read(input logic [15:0] ba,
                                                 input logic        live_hi);
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_window(ba)) begin
      case (ba[2:0])
        3'd0: v = {5'b0, ie, periodic, en};
        3'd1: v = {7'b0, exp_flag};
        3'd2: v = reload[7:0];
        3'd3: v = reload[15:8];
        3'd4: v = count[7:0];
        3'd5: v = live_hi ? count[15:8] : hi_latch;
        3'd6: v = prescale;
`ifdef IO_TIMER_PWM_EN
        3'd7: v = compare;
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Address decode: the even lane always lands on even offsets and the odd
  // lane on odd offsets, so the two lanes never collide.
  logic [15:0] rd_ba_even, rd_ba_odd, wr_ba_even, wr_ba_odd;
  assign rd_ba_even = {read_addr_even, 1'b0};
  assign rd_ba_odd  = {read_addr_odd, 1'b1};
  assign wr_ba_even = {write_addr_even, 1'b0};
  assign wr_ba_odd  = {write_addr_odd, 1'b1};

  logic rd_lo_even, rd_lo_odd;
  assign rd_lo_even = in_window(rd_ba_even) && (rd_ba_even[2:0] == 3'd4);
  assign rd_lo_odd  = in_window(rd_ba_odd)  && (rd_ba_odd[2:0]  == 3'd4);

  // One-hot per-offset write select; data comes from the lane matching the
  // offset parity.
  logic [7:0] wr_sel;
  always_comb begin
    wr_sel = '0;
    if (write_en_even && in_window(wr_ba_even)) wr_sel[wr_ba_even[2:0]] = 1'b1;
    if (write_en_odd  && in_window(wr_ba_odd))  wr_sel[wr_ba_odd[2:0]]  = 1'b1;
  end

  logic              ctrl_wr, load, en_rise, status_clr, tick, expire;
  logic [15:0]       reload_d;
  logic [DATA_W-1:0] prescale_d;

  assign ctrl_wr    = wr_sel[0];
  assign load       = ctrl_wr & write_data_even[3];
  assign en_rise    = ctrl_wr & write_data_even[0] & ~en;
  assign status_clr = wr_sel[1] & write_data_odd[0];
  assign tick       = en & (presc_cnt == prescale);
  // LOAD pre-empts a coincident tick, so it also suppresses expiry.
  assign expire     = tick & (count == 16'd0) & ~load;

  assign reload_d   = {wr_sel[3] ? write_data_odd  : reload[15:8],
                       wr_sel[2] ? write_data_even : reload[7:0]};
  assign prescale_d = wr_sel[6] ? write_data_even : prescale;

  logic              en_d, periodic_d, ie_d, exp_d, int_d;
  logic [15:0]       count_d;
  logic [DATA_W-1:0] presc_d, hi_latch_d, rd_even_d, rd_odd_d;

  always_comb begin
    en_d       = ctrl_wr ? write_data_even[0] : en;
    periodic_d = ctrl_wr ? write_data_even[1] : periodic;
    ie_d       = ctrl_wr ? write_data_even[2] : ie;
    // A one-shot expiry stops the timer unless software rewrites CTRL in
    // the same cycle, in which case the written EN stands.
    if (expire && !periodic && !ctrl_wr) en_d = 1'b0;

    count_d = count;
    if (load) begin
      count_d = reload_d;
    end else if (tick) begin
      if (count != 16'd0)  count_d = count - 16'd1;
      else if (periodic)   count_d = reload_d;
    end

    presc_d = presc_cnt;
    if (load || en_rise || tick) presc_d = '0;
    else if (en)                 presc_d = presc_cnt + 8'd1;

    // Expiry beats a simultaneous software clear.
    exp_d = exp_flag;
    if (expire)          exp_d = 1'b1;
    else if (status_clr) exp_d = 1'b0;

    int_d = exp_d & ie_d;

    hi_latch_d = (rd_lo_even || rd_lo_odd) ? count[15:8] : hi_latch;
    rd_even_d  = reg_read(rd_ba_even, rd_lo_odd);
    rd_odd_d   = reg_read(rd_ba_odd,  rd_lo_even);
  end

  // Register stage: state, interrupt and read data all update together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en             <= 1'b0;
      periodic       <= 1'b0;
      ie             <= 1'b0;
      exp_flag       <= 1'b0;
      reload         <= '0;
      count          <= '0;
      prescale       <= PRESCALE_RESET;
      presc_cnt      <= '0;
      hi_latch       <= '0;
      interrupt      <= 1'b0;
      read_data_even <= '0;
      read_data_odd  <= '0;
    end else begin
      en             <= en_d;
      periodic       <= periodic_d;
      ie             <= ie_d;
      exp_flag       <= exp_d;
      reload         <= reload_d;
      count          <= count_d;
      prescale       <= prescale_d;
      presc_cnt      <= presc_d;
      hi_latch       <= hi_latch_d;
      interrupt      <= int_d;
      read_data_even <= rd_even_d;
      read_data_odd  <= rd_odd_d;
    end
  end

`ifdef IO_TIMER_PWM_EN
  // PWM stage: compares the current count, so it trails count by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      compare <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr_sel[7]) compare <= write_data_odd;
      pwm_out <= en & (count[15:8] < compare);
    end
  end
`else
  assign pwm_out = 1'b0;
  logic unused_compare_wr;
  assign unused_compare_wr = wr_sel[7];
`endif

endmodule
